// File: rtl/ctx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctx_sequencer_if
//  Description : Bundle of the configuration-write, run-control and context
//                output signals of the per-PE context sequencer.
//                master : config loader / controller / PE decoder side
//                slave  : the sequencer itself
//  Ports       : cfg_wr_en/addr/data, cfg_wr_ack   context-memory write port
//                start, ctx_len, iter_cnt          run launch and arguments
//                stall, abort                      run-time control
//                ctx_out, ctx_idx, ctx_valid       issued context word
//                busy, done, err                   status
//  Revision    : 1.0  initial release
// ============================================================================
interface ctx_sequencer_if #(
    parameter int WIDTH = 120,
    parameter int AW    = 4,
    parameter int ITW   = 16
);
    logic               cfg_wr_en;
    logic [AW-1:0]      cfg_wr_addr;
    logic [WIDTH:0]     cfg_wr_data;
    logic               cfg_wr_ack;
    logic               start;
    logic [AW:0]        ctx_len;
    logic [ITW-1:0]     iter_cnt;
    logic               stall;
    logic               abort;
    logic [WIDTH:0]     ctx_out;
    logic [AW-1:0]      ctx_idx;
    logic               ctx_valid;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, start, ctx_len, iter_cnt,
               stall, abort,
        input  cfg_wr_ack, ctx_out, ctx_idx, ctx_valid, busy, done, err
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, start, ctx_len, iter_cnt,
               stall, abort,
        output cfg_wr_ack, ctx_out, ctx_idx, ctx_valid, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/ctx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctx_sequencer
//  Description : Per-PE context sequencer. Stores DEPTH configuration words
//                and, once started, issues one word per cycle to the PE
//                decoder, looping over ctx_len contexts for iter_cnt
//                iterations.
//  Ports       : CLK   clock, rising edge
//                RST   synchronous reset, active-high
//                bus   ctx_sequencer_if.slave (write port, run control,
//                      context output, status)
//  Revision    : 1.0  initial release
// ============================================================================
module ctx_sequencer #(
    parameter int WIDTH = 120,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int ITW   = 16
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    ctx_sequencer_if.slave   bus
);

    localparam logic [1:0]     c_IDLE     = 2'd0;
    localparam logic [1:0]     c_RUN      = 2'd1;
    localparam logic [1:0]     c_DONE     = 2'd2;
    localparam logic [AW:0]    c_ONE_LEN  = 1;
    localparam logic [AW:0]    c_DEPTH    = DEPTH[AW:0];
    localparam logic [AW-1:0]  c_ONE_PC   = 1;
    localparam logic [ITW-1:0] c_ONE_ITER = 1;

    // Context memory: not reset, survives RST.
    logic [WIDTH:0] mem_q [DEPTH];

    logic [1:0]     state_q,     state_d;
    logic [AW-1:0]  pc_q,        pc_d;
    logic [ITW-1:0] iter_q,      iter_d;
    logic [AW:0]    len_q,       len_d;
    logic [WIDTH:0] ctx_out_q,   ctx_out_d;
    logic [AW-1:0]  ctx_idx_q,   ctx_idx_d;
    logic           ctx_valid_q, ctx_valid_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
    logic           err_q,       err_d;

    logic w_idle;
    logic w_mem_we;
    logic w_args_ok;
    logic w_last_pc;

    assign w_idle    = (state_q == c_IDLE);
    assign w_mem_we  = w_idle && bus.cfg_wr_en;
    assign w_args_ok = (bus.ctx_len != '0) && (bus.ctx_len <= c_DEPTH) &&
                       (bus.iter_cnt != '0);
    // len_q is at least 1 in RUN, so len_q-1 never underflows there.
    assign w_last_pc = ({1'b0, pc_q} == (len_q - c_ONE_LEN));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iter_d      = iter_q;
        len_d       = len_q;
        ctx_out_d   = '0;
        ctx_idx_d   = ctx_idx_q;
        ctx_valid_d = 1'b0;
        done_d      = 1'b0;
        // Any write outside IDLE is rejected and flagged.
        err_d       = bus.cfg_wr_en && !w_idle;

        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    if (w_args_ok) begin
                        len_d   = bus.ctx_len;
                        iter_d  = bus.iter_cnt;
                        pc_d    = '0;
                        state_d = c_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            c_RUN: begin
                if (bus.abort) begin
                    state_d = c_IDLE;
                end else if (!bus.stall) begin
                    ctx_out_d   = mem_q[pc_q];
                    ctx_idx_d   = pc_q;
                    ctx_valid_d = 1'b1;
                    if (w_last_pc) begin
                        pc_d   = '0;
                        iter_d = iter_q - c_ONE_ITER;
                        if (iter_q == c_ONE_ITER) begin
                            state_d = c_DONE;
                        end
                    end else begin
                        pc_d = pc_q + c_ONE_PC;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                done_d  = !bus.abort;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        // busy tracks the state register itself, so it drops together with done.
        busy_d = (state_d != c_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= c_IDLE;
            pc_q        <= '0;
            iter_q      <= '0;
            len_q       <= '0;
            ctx_out_q   <= '0;
            ctx_idx_q   <= '0;
            ctx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iter_q      <= iter_d;
            len_q       <= len_d;
            ctx_out_q   <= ctx_out_d;
            ctx_idx_q   <= ctx_idx_d;
            ctx_valid_q <= ctx_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            mem_q[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    assign bus.cfg_wr_ack = w_idle;
    assign bus.ctx_out    = ctx_out_q;
    assign bus.ctx_idx    = ctx_idx_q;
    assign bus.ctx_valid  = ctx_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
`default_nettype wire
